reply_counter: RTL and testbench

- UART-side command handler, enabled by the top-level state watcher when command byte 0x72 is received.
- Once activated, it takes one length byte N from the UART receiver and transmits N bytes counting up from START_VALUE through the UART transmitter.
- It then asserts done so the top level returns to its ready state.
- It shares the tx_data/tx_start path with the other command handlers through the top-level TX multiplexer.

---
 rtl/reply_counter_pkg.sv | 26 ++
 rtl/reply_counter_rise_detect.sv | 24 ++
 rtl/reply_counter.sv | 193 +++++++++++++++++++
 tb/tb_reply_counter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reply_counter_pkg.sv
// Shared definitions for the reply_counter command handler: FSM state
// encoding, default parameter values and the command code that selects it.
// REPLY_CNT_ECHO_EN adds the ECHO state used to acknowledge the length byte.
package reply_counter_pkg;

  // Command byte the top-level state watcher decodes to enable this handler
  localparam logic [7:0] CMD_REPLY_COUNTER = 8'h72;

  // Default parameter values
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_START_VALUE = 0;
  localparam int DEF_STEP        = 1;

  // Handler states; ECHO exists only when the acknowledge byte is enabled
  typedef enum logic [2:0] {
    IDLE,
    WAIT_LEN,
    SEND,
    WAIT_TX,
    DONE
`ifdef REPLY_CNT_ECHO_EN
    , ECHO
`endif
  } state_e;

endpackage

// File: rtl/reply_counter_rise_detect.sv
// Rising-edge detector for the UART receiver data-valid strobe.
// The history register resets to 1 so a strobe that is already high when the
// handler starts (left over from the command byte) never reads as a new byte.
module reply_counter_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  // Remember the previous strobe level; reset value suppresses a false edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= d_i;
    end
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/reply_counter.sv
// reply_counter: reads one length byte N from the UART receiver and sends N
// count bytes (START_VALUE, START_VALUE+STEP, ... modulo 2^DATA_W) to the UART
// transmitter, then raises done until activate falls. Dropping activate aborts.
// Optional macro REPLY_CNT_ECHO_EN: the length byte is first echoed back as an
// acknowledge byte before the count bytes (N=0 echoes a lone 0x00).
module reply_counter
  import reply_counter_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int START_VALUE = DEF_START_VALUE,
  parameter int STEP        = DEF_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              activate,
  output logic              done,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_active,
  input  logic              tx_done
);

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic                tx_start_q, tx_start_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [DATA_W-1:0]   len_q, len_d;
  logic [DATA_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]   sent_q, sent_d;
  logic [DATA_W-1:0]   sent_inc;
  logic                rx_rise;
`ifdef REPLY_CNT_ECHO_EN
  logic                echo_sent_q, echo_sent_d;
`endif

  // Next count byte; the sum wraps naturally at the register width
  function automatic logic [DATA_W-1:0] next_count(input logic [DATA_W-1:0] c);
    return c + DATA_W'(STEP);
  endfunction

  reply_counter_rise_detect u_rise (
    .clk    (clk),
    .reset  (reset),
    .d_i    (rx_ready),
    .rise_o (rx_rise)
  );

  assign sent_inc = sent_q + DATA_W'(1);

  // Next-state and registered-output decisions for the handler FSM
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    len_d      = len_q;
    count_d    = count_q;
    sent_d     = sent_q;
`ifdef REPLY_CNT_ECHO_EN
    echo_sent_d = echo_sent_q;
`endif

    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (activate) begin
          state_d = WAIT_LEN;
        end
      end

      WAIT_LEN: begin
        if (rx_rise) begin
          len_d   = rx_data;
          count_d = DATA_W'(START_VALUE);
          sent_d  = '0;
`ifdef REPLY_CNT_ECHO_EN
          // Acknowledge first, even for a zero length
          echo_sent_d = 1'b0;
          state_d     = ECHO;
`else
          if (rx_data == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SEND;
          end
`endif
        end
      end

`ifdef REPLY_CNT_ECHO_EN
      ECHO: begin
        // Send the latched length once, then wait for it to leave the wire
        if (!echo_sent_q) begin
          if (!tx_active) begin
            tx_data_d   = len_q;
            tx_start_d  = 1'b1;
            echo_sent_d = 1'b1;
          end
        end else if (tx_done) begin
          if (len_q == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SEND;
          end
        end
      end
`endif

      SEND: begin
        // Only one byte outstanding: hold off while the transmitter is busy
        if (!tx_active) begin
          tx_data_d  = count_q;
          tx_start_d = 1'b1;
          state_d    = WAIT_TX;
        end
      end

      WAIT_TX: begin
        if (tx_done) begin
          count_d = next_count(count_q);
          sent_d  = sent_inc;
          if (sent_inc == len_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SEND;
          end
        end
      end

      DONE: begin
        done_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    endcase

    // Losing activate abandons the sequence from any busy state; a byte
    // already handed to the transmitter is left to finish on its own
    if (!activate && (state_q != IDLE)) begin
      state_d    = IDLE;
      done_d     = 1'b0;
      tx_start_d = 1'b0;
`ifdef REPLY_CNT_ECHO_EN
      echo_sent_d = 1'b0;
`endif
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      len_q      <= '0;
      count_q    <= '0;
      sent_q     <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      len_q      <= len_d;
      count_q    <= count_d;
      sent_q     <= sent_d;
    end
  end

`ifdef REPLY_CNT_ECHO_EN
  // Tracks whether the acknowledge byte has been issued in ECHO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_sent_q <= 1'b0;
    end else begin
      echo_sent_q <= echo_sent_d;
    end
  end
`endif

  assign done     = done_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_reply_counter.sv
// Directed bench for reply_counter. Two instances share all inputs: one with
// the default START_VALUE and one starting at 0xFE to exercise count wrap.
// A transmitter model answers each tx_start with 10 busy cycles and a
// one-cycle tx_done pulse. Define REPLY_CNT_ECHO_EN for the echo build.
module tb_reply_counter;
  import reply_counter_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       activate = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_active = 1'b0;
  logic       tx_done = 1'b0;

  logic       done, tx_start;
  logic [7:0] tx_data;
  logic       done_fe, tx_start_fe;
  logic [7:0] tx_data_fe;

  int checks = 0;
  int failures = 0;

  logic [7:0] q_main[$];
  logic [7:0] q_fe[$];
  int overlap = 0;
  int sync_err = 0;
  int busy_cnt = 0;
  bit busy = 1'b0;

  reply_counter dut (
    .clk(clk), .reset(reset), .activate(activate), .done(done),
    .rx_ready(rx_ready), .rx_data(rx_data), .tx_data(tx_data),
    .tx_start(tx_start), .tx_active(tx_active), .tx_done(tx_done)
  );

  reply_counter #(.START_VALUE(8'hFE)) dut_fe (
    .clk(clk), .reset(reset), .activate(activate), .done(done_fe),
    .rx_ready(rx_ready), .rx_data(rx_data), .tx_data(tx_data_fe),
    .tx_start(tx_start_fe), .tx_active(tx_active), .tx_done(tx_done)
  );

  always #10 clk = ~clk;

  // Transmitter model and byte recorder
  always begin
    @(posedge clk); #1;
    if (tx_start_fe !== tx_start) sync_err++;
    if (tx_start === 1'b1) begin
      q_main.push_back(tx_data);
      q_fe.push_back(tx_data_fe);
      if (busy) overlap++;
      else begin
        busy = 1'b1; busy_cnt = 10; tx_active = 1'b1;
      end
    end else if (busy) begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          tx_active = 1'b0; tx_done = 1'b1;
        end
      end else begin
        tx_done = 1'b0; busy = 1'b0;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, done=%0b", done);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_len(input logic [7:0] n, input int hold);
    rx_data = n; rx_ready = 1'b1;
    repeat (hold) step();
    rx_ready = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) step();
  endtask

  function automatic bq_t build_exp(input int len, input logic [7:0] start);
    bq_t e;
    logic [7:0] v;
    e = {};
    v = start;
`ifdef REPLY_CNT_ECHO_EN
    e.push_back(8'(len));
`endif
    for (int i = 0; i < len; i++) begin
      e.push_back(v);
      v = v + 8'd1;
    end
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done);
    if (done !== 1'b0) failures++;
    checks++; if (tx_start !== 1'b0) begin $display("FAIL reset_tx_start: got %0b want 0", tx_start); failures++; end
    checks++; if (tx_data !== 8'h00 || tx_data_fe !== 8'h00) begin $display("FAIL reset_tx_data: got %h/%h want 00", tx_data, tx_data_fe); failures++; end
    checks++; if (dut.state_q !== IDLE) begin $display("FAIL reset_state: got %0d want IDLE", dut.state_q); failures++; end
    checks++; if (dut.u_rise.prev_q !== 1'b1) begin $display("FAIL reset_rx_hist: got %0b want 1", dut.u_rise.prev_q); failures++; end
    reset = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_count3();
    int base;
    bq_t em, ef;
    base = q_main.size();
    em = build_exp(3, 8'h00);
    ef = build_exp(3, 8'hFE);
    activate = 1'b1;
    step(); step();
    send_len(8'h03, 1);
    wait_done(300);
    checks++; if (done !== 1'b1) begin $display("FAIL count3_done: got %0b want 1", done); failures++; end
    checks++; if (done_fe !== 1'b1) begin $display("FAIL count3_done_fe: got %0b want 1", done_fe); failures++; end
    checks++; if (q_main.size() - base != em.size()) begin $display("FAIL count3_nbytes: got %0d want %0d", q_main.size() - base, em.size()); failures++; end
    for (int i = 0; i < em.size() && base + i < q_main.size(); i++) begin
      checks++; if (q_main[base+i] !== em[i]) begin $display("FAIL count3_byte%0d: got %h want %h", i, q_main[base+i], em[i]); failures++; end
      checks++; if (q_fe[base+i] !== ef[i]) begin $display("FAIL wrapfe_byte%0d: got %h want %h", i, q_fe[base+i], ef[i]); failures++; end
    end
    activate = 1'b0;
    step();
    checks++; if (done !== 1'b0) begin $display("FAIL count3_done_clear: got %0b want 0", done); failures++; end
    repeat (3) step();
  endtask

  task automatic test_len0();
    int base;
    int budget;
    bq_t em;
    base = q_main.size();
    em = build_exp(0, 8'h00);
`ifdef REPLY_CNT_ECHO_EN
    budget = 40;
`else
    budget = 1;
`endif
    activate = 1'b1;
    step(); step();
    send_len(8'h00, 1);
    wait_done(budget);
    checks++; if (done !== 1'b1) begin $display("FAIL len0_done: got %0b want 1", done); failures++; end
    repeat (3) step();
    checks++; if (q_main.size() - base != em.size()) begin $display("FAIL len0_nbytes: got %0d want %0d", q_main.size() - base, em.size()); failures++; end
    for (int i = 0; i < em.size() && base + i < q_main.size(); i++) begin
      checks++; if (q_main[base+i] !== em[i]) begin $display("FAIL len0_byte%0d: got %h want %h", i, q_main[base+i], em[i]); failures++; end
    end
    activate = 1'b0;
    step();
    checks++; if (done !== 1'b0) begin $display("FAIL len0_done_clear: got %0b want 0", done); failures++; end
    repeat (3) step();
  endtask

  task automatic test_held_high();
    int base;
    bq_t em;
    base = q_main.size();
    em = build_exp(2, 8'h00);
    activate = 1'b1;
    step(); step();
    send_len(8'h02, 20);
    wait_done(300);
    repeat (3) step();
    checks++; if (done !== 1'b1) begin $display("FAIL held_done: got %0b want 1", done); failures++; end
    checks++; if (q_main.size() - base != em.size()) begin $display("FAIL held_nbytes: got %0d want %0d", q_main.size() - base, em.size()); failures++; end
    for (int i = 0; i < em.size() && base + i < q_main.size(); i++) begin
      checks++; if (q_main[base+i] !== em[i]) begin $display("FAIL held_byte%0d: got %h want %h", i, q_main[base+i], em[i]); failures++; end
    end
    activate = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_stale_rx();
    int base;
    base = q_main.size();
    rx_data = 8'h03; rx_ready = 1'b1;
    step(); step();
    activate = 1'b1;
    repeat (6) step();
    rx_ready = 1'b0;
    repeat (4) step();
    checks++; if (q_main.size() != base) begin $display("FAIL stale_rx_bytes: got %0d want 0", q_main.size() - base); failures++; end
    checks++; if (dut.state_q !== WAIT_LEN) begin $display("FAIL stale_rx_state: got %0d want WAIT_LEN", dut.state_q); failures++; end
    activate = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_abort();
    int base;
    bit done_seen;
    bq_t em;
    base = q_main.size();
    em = build_exp(5, 8'h00);
    done_seen = 1'b0;
    activate = 1'b1;
    step(); step();
    send_len(8'h05, 1);
    for (int i = 0; i < 100 && tx_done !== 1'b1; i++) step();
    checks++; if (tx_done !== 1'b1) begin $display("FAIL abort_first_txdone: got %0b want 1", tx_done); failures++; end
    activate = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done !== 1'b0) done_seen = 1'b1;
    end
    checks++; if (done_seen) begin $display("FAIL abort_done: got 1 want 0"); failures++; end
    checks++; if (q_main.size() - base != 1) begin $display("FAIL abort_nbytes: got %0d want 1", q_main.size() - base); failures++; end
    if (q_main.size() > base) begin
      checks++; if (q_main[base] !== em[0]) begin $display("FAIL abort_byte0: got %h want %h", q_main[base], em[0]); failures++; end
    end
    checks++; if (dut.state_q !== IDLE) begin $display("FAIL abort_state: got %0d want IDLE", dut.state_q); failures++; end
  endtask

  task automatic test_reset_mid_send();
    int base;
    state_e exp_st;
`ifdef REPLY_CNT_ECHO_EN
    exp_st = ECHO;
`else
    exp_st = SEND;
`endif
    base = q_main.size();
    activate = 1'b1;
    step(); step();
    send_len(8'h03, 1);
    checks++; if (dut.state_q !== exp_st) begin $display("FAIL rstmid_pre_state: got %0d want %0d", dut.state_q, exp_st); failures++; end
    reset = 1'b1;
    #1;
    checks++; if (dut.state_q !== IDLE) begin $display("FAIL rstmid_state: got %0d want IDLE", dut.state_q); failures++; end
    checks++; if (done !== 1'b0 || tx_start !== 1'b0) begin $display("FAIL rstmid_outputs: got done=%0b tx_start=%0b want 0/0", done, tx_start); failures++; end
    step();
    reset = 1'b0;
    activate = 1'b0;
    repeat (5) step();
    checks++; if (q_main.size() != base) begin $display("FAIL rstmid_bytes: got %0d want 0", q_main.size() - base); failures++; end
    checks++; if (done !== 1'b0) begin $display("FAIL rstmid_done: got %0b want 0", done); failures++; end
  endtask

  task automatic test_protocol();
    checks++; if (overlap != 0) begin $display("FAIL tx_overlap: got %0d want 0", overlap); failures++; end
    checks++; if (sync_err != 0) begin $display("FAIL fe_start_timing: got %0d want 0", sync_err); failures++; end
  endtask

  initial begin
    test_reset();
    test_count3();
    test_len0();
    test_held_high();
    test_stale_rx();
    test_abort();
    repeat (20) step();
    test_reset_mid_send();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
